dmem_access_unit: RTL and testbench

- Memory-stage data-memory access unit between the pipeline M stage and a single-ported, variable-latency data SRAM using a req/ack handshake.
- Consumes the M-stage address, store data, byte enables and load/store strobes; returns lane-extracted load data.
- Raises a stall while a load or blocked store is outstanding.
- A one-entry posted write buffer lets stores retire in one cycle.

---
 rtl/dmem_access_unit.sv | 146 ++++++++++++++
 tb/tb_dmem_access_unit.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: M-stage data-memory access unit with a one-entry posted write buffer.
// Latency: stores retire in 1 cycle; a load acked after N request cycles stalls N+1 cycles, data presented the cycle after.
// Backpressure: StallM holds the pipeline during loads and while a store meets a full buffer that is not acked this cycle.
//
// Ports:
//   clk, reset            pipeline clock, synchronous active-low reset
//   MemReadM/MemWriteM    load/store strobes of the M-stage instruction
//   ByteEnM, AddrM        byte enables (byte/halfword/word) and effective address
//   WriteDataM            right-justified store data
//   ReadDataM, StallM     zero-extended load data, pipeline hold
//   mem_*                 req/ack SRAM interface; all outputs registered, mem_rdata valid with mem_ack
module dmem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_W/8-1:0]   ByteEnM,
  input  logic [ADDR_W-1:0]     AddrM,
  input  logic [DATA_W-1:0]     WriteDataM,
  output logic [DATA_W-1:0]     ReadDataM,
  output logic                  StallM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  state_t            state;
  logic              wb_valid;
  logic [BE_W-1:0]   rd_be;        // byte enables of the load in flight
  logic [ADDR_W-1:0] addr_aligned;
  logic [DATA_W-1:0] store_word;
  logic [DATA_W-1:0] load_word;
  logic              wr_done;
  logic              store_op;
  logic              store_take;
  logic              load_start;

  assign addr_aligned = AddrM & {{(ADDR_W-2){1'b1}}, 2'b00};

  // The write buffer lives in the registered mem_addr/mem_wdata/mem_be
  // outputs; wb_valid marks them as holding an undrained store, and the
  // write request is raised the same edge the store is captured.
  assign wr_done    = wb_valid && mem_req && mem_we && mem_ack;
  assign store_op   = MemWriteM && !MemReadM;   // load wins if both are set
  assign store_take = store_op && (state != RD_WAIT) && (!wb_valid || wr_done);
  // Loads never bypass a pending store: wait until the buffer is empty.
  assign load_start = (state == IDLE) && MemReadM && !wb_valid;

  always_comb begin
    StallM = 1'b0;
    if (reset) begin
      StallM = ((state == IDLE) && MemReadM) ||
               (state == RD_WAIT) ||
               (store_op && wb_valid && !wr_done);
    end
  end

  // Replicate right-justified store data across all lanes so the SRAM can
  // pick it up with mem_be alone.
  always_comb begin
    store_word = WriteDataM;
    case (ByteEnM)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: store_word = {4{WriteDataM[7:0]}};
      4'b0011, 4'b1100:                   store_word = {2{WriteDataM[15:0]}};
      default:                            store_word = WriteDataM;
    endcase
  end

  // Extract and zero-extend the addressed lane; illegal patterns give the word.
  always_comb begin
    load_word = mem_rdata;
    case (rd_be)
      4'b0001: load_word = {24'd0, mem_rdata[7:0]};
      4'b0010: load_word = {24'd0, mem_rdata[15:8]};
      4'b0100: load_word = {24'd0, mem_rdata[23:16]};
      4'b1000: load_word = {24'd0, mem_rdata[31:24]};
      4'b0011: load_word = {16'd0, mem_rdata[15:0]};
      4'b1100: load_word = {16'd0, mem_rdata[31:16]};
      default: load_word = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wb_valid  <= 1'b0;
      rd_be     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      ReadDataM <= '0;
    end else if (state == RD_WAIT) begin
      if (mem_ack) begin
        ReadDataM <= load_word;
        mem_req   <= 1'b0;
        state     <= RD_DONE;
      end
    end else begin
      // RD_DONE lasts one cycle and never starts a request, even though
      // the completed load still shows MemReadM this cycle.
      if (state == RD_DONE) begin
        state <= IDLE;
      end

      if (store_take) begin
        // Either the buffer was empty or its drain is acked this cycle;
        // refill it and keep the write request up without a gap.
        wb_valid  <= 1'b1;
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= addr_aligned;
        mem_wdata <= store_word;
        mem_be    <= ByteEnM;
      end else if (wr_done) begin
        wb_valid <= 1'b0;
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
      end else if (load_start) begin
        state    <= RD_WAIT;
        rd_be    <= ByteEnM;
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= addr_aligned;
        mem_be   <= '1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: self-checking bench for dmem_access_unit.
// Latency: drives one M-stage instruction at a time, honouring StallM; memory acks after a programmable delay.
// Backpressure: an instruction is held on the inputs until StallM is low at the end of its cycle.
module tb_dmem_access_unit;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [3:0]  ByteEnM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // Memory responder controls.
  int ack_delay  = 1;
  bit resp_en    = 1'b1;
  bit inject_ack = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         wr_log[$];        // writes seen on the bus, in ack order
  wr_t         exp_wr[$];        // writes expected, in program order
  logic [31:0] mem     [0:255];  // memory behind the bus
  logic [31:0] ref_mem [0:255];  // architectural memory of the reference model

  dmem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ByteEnM    (ByteEnM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (reset) begin
      assert (!(MemReadM && MemWriteM))
        else $error("FAIL illegal_ld_st read=%b write=%b", MemReadM, MemWriteM);
    end
  end

  // ---------------- reference model ----------------
  function automatic int popc(input logic [3:0] be);
    int n = 0;
    for (int k = 0; k < 4; k++) if (be[k]) n++;
    return n;
  endfunction

  function automatic int low_lane(input logic [3:0] be);
    for (int k = 0; k < 4; k++) if (be[k]) return k;
    return 0;
  endfunction

  function automatic bit legal_be(input logic [3:0] be);
    return (popc(be) == 1) || (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] be);
    logic [31:0] w;
    int          n;
    w = ref_mem[a[9:2]];
    if (!legal_be(be)) return w;
    n = popc(be);
    if (n == 4) return w;
    return (w >> (8 * low_lane(be))) & ((32'd1 << (8 * n)) - 32'd1);
  endfunction

  // Right-justified data lands in the lanes picked by be, starting at the lowest.
  function automatic void ref_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int          lo;
    logic [31:0] bus;
    lo = low_lane(be);
    for (int k = 0; k < 4; k++)
      if (be[k]) ref_mem[a[9:2]][8*k +: 8] = d[8*(k-lo) +: 8];
    case (popc(be))
      1:       bus = {4{d[7:0]}};
      2:       bus = {2{d[15:0]}};
      default: bus = d;
    endcase
    exp_wr.push_back({a & 32'hFFFF_FFFC, bus, be});
  endfunction

  // ---------------- memory responder ----------------
  initial begin : responder
    int          wcnt;
    bit          prev_pend;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        pw;
    wcnt = 0; prev_pend = 1'b0; pa = '0; pd = '0; pw = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        mem_ack   = inject_ack;
        mem_rdata = 32'hFFFF_FFFF;
        wcnt      = 0;
        prev_pend = 1'b0;
      end else begin
        if (reset && prev_pend) begin
          checks++;
          if (!mem_req || mem_addr !== pa || mem_we !== pw || (pw && mem_wdata !== pd)) begin
            errors++;
            $display("FAIL bus_hold req=%b we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                     mem_req, mem_we, mem_addr, mem_wdata, pw, pa, pd);
          end
        end
        mem_ack = 1'b0;
        if (reset && mem_req) begin
          wcnt++;
          if (wcnt >= ack_delay) begin
            mem_ack   = 1'b1;
            wcnt      = 0;
            prev_pend = 1'b0;
            if (mem_we) begin
              for (int k = 0; k < 4; k++)
                if (mem_be[k]) mem[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
              wr_log.push_back({mem_addr, mem_wdata, mem_be});
            end else begin
              mem_rdata = mem[mem_addr[9:2]];
            end
          end else begin
            prev_pend = 1'b1;
            pa = mem_addr;
            pd = mem_wdata;
            pw = mem_we;
          end
        end else begin
          wcnt      = 0;
          prev_pend = 1'b0;
        end
      end
    end
  end

  // ---------------- pipeline-side drivers ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] be, output logic [31:0] data,
                         output int stalls, output logic [31:0] rd_addr, output int wlog_at_rd);
    bit seen;
    @(negedge clk);
    MemReadM = 1'b1; MemWriteM = 1'b0; AddrM = a; ByteEnM = be; WriteDataM = $urandom;
    stalls = 0; seen = 1'b0; rd_addr = '0; wlog_at_rd = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!seen && mem_req && !mem_we) begin
        seen = 1'b1; rd_addr = mem_addr; wlog_at_rd = wr_log.size();
      end
      if (!StallM) break;
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 100) begin
      checks++; errors++;
      $display("FAIL load_timeout addr=%h stalled=%0d cycles", a, stalls);
    end
    data = ReadDataM;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int stalls);
    @(negedge clk);
    MemReadM = 1'b0; MemWriteM = 1'b1; AddrM = a; WriteDataM = d; ByteEnM = be;
    ref_store(a, d, be);
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!StallM) break;
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 100) begin
      checks++; errors++;
      $display("FAIL store_timeout addr=%h stalled=%0d cycles", a, stalls);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    idle_cycles(3);
    #1;
    checks += 7;
    if (mem_req !== 1'b0)    begin errors++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    if (mem_addr !== 32'd0)  begin errors++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    if (mem_wdata !== 32'd0) begin errors++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
    if (mem_be !== 4'd0)     begin errors++; $display("FAIL rst_mem_be got=%b want=0", mem_be); end
    if (ReadDataM !== 32'd0) begin errors++; $display("FAIL rst_rdata got=%h want=0", ReadDataM); end
    if (StallM !== 1'b0)     begin errors++; $display("FAIL rst_stall got=%b want=0", StallM); end
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    resp_en = 1'b0;
    @(negedge clk);
    MemReadM = 1'b1; MemWriteM = 1'b0; AddrM = 32'h80; ByteEnM = 4'hF;
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL midrd_req_before got=%b want=1", mem_req); end
    reset = 1'b0; MemReadM = 1'b0;
    @(negedge clk);
    #1;
    checks += 3;
    if (mem_req !== 1'b0)    begin errors++; $display("FAIL midrd_req_after got=%b want=0", mem_req); end
    if (StallM !== 1'b0)     begin errors++; $display("FAIL midrd_stall_after got=%b want=0", StallM); end
    if (ReadDataM !== 32'd0) begin errors++; $display("FAIL midrd_rdata_after got=%h want=0", ReadDataM); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 inject_ack = 1'b1;
    @(posedge clk); #1 inject_ack = 1'b0;
    @(negedge clk);
    #1;
    checks += 3;
    if (mem_req !== 1'b0)    begin errors++; $display("FAIL late_ack_req got=%b want=0", mem_req); end
    if (StallM !== 1'b0)     begin errors++; $display("FAIL late_ack_stall got=%b want=0", StallM); end
    if (ReadDataM !== 32'd0) begin errors++; $display("FAIL late_ack_rdata got=%h want=0", ReadDataM); end
    resp_en = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_word_load();
    logic [31:0] d;
    logic [31:0] ra;
    int          st;
    int          wl;
    ack_delay = 1;
    do_store(32'h100, 32'hDEAD_BEEF, 4'hF, st);
    idle_cycles(4);
    ack_delay = 3;
    do_load(32'h100, 4'hF, d, st, ra, wl);
    checks += 3;
    if (st !== 4)              begin errors++; $display("FAIL word_load_stalls got=%0d want=4", st); end
    if (d !== 32'hDEAD_BEEF)   begin errors++; $display("FAIL word_load_data got=%h want=deadbeef", d); end
    if (ra !== 32'h100)        begin errors++; $display("FAIL word_load_addr got=%h want=100", ra); end
    idle_cycles(3);
    #1;
    checks++;
    if (ReadDataM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdata_hold got=%h want=deadbeef", ReadDataM); end
  endtask

  task automatic test_subword_loads();
    logic [3:0]  bes  [4] = '{4'b0001, 4'b0011, 4'b0100, 4'b1100};
    logic [31:0] want [4] = '{32'h0000_00EF, 32'h0000_BEEF, 32'h0000_00AD, 32'h0000_DEAD};
    logic [31:0] d;
    logic [31:0] ra;
    int          st;
    int          wl;
    ack_delay = 2;
    for (int i = 0; i < 4; i++) begin
      do_load(32'h100 | 32'(i), bes[i], d, st, ra, wl);
      checks += 2;
      if (d !== want[i]) begin errors++; $display("FAIL subword_data be=%b got=%h want=%h", bes[i], d, want[i]); end
      if (st !== 3)      begin errors++; $display("FAIL subword_stalls be=%b got=%0d want=3", bes[i], st); end
      idle_cycles(1);
    end
  endtask

  task automatic test_posted_store();
    int st;
    ack_delay = 2;
    do_store(32'h203, 32'h0000_005A, 4'b1000, st);
    checks++;
    if (st !== 0) begin errors++; $display("FAIL bstore_stalls got=%0d want=0", st); end
    idle_cycles(1);
    #1;
    checks += 6;
    if (mem_req !== 1'b1)           begin errors++; $display("FAIL bstore_req got=%b want=1", mem_req); end
    if (mem_we !== 1'b1)            begin errors++; $display("FAIL bstore_we got=%b want=1", mem_we); end
    if (mem_addr !== 32'h200)       begin errors++; $display("FAIL bstore_addr got=%h want=200", mem_addr); end
    if (mem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL bstore_wdata got=%h want=5a5a5a5a", mem_wdata); end
    if (mem_be !== 4'b1000)         begin errors++; $display("FAIL bstore_be got=%b want=1000", mem_be); end
    if (ReadDataM !== 32'h0000_DEAD) begin errors++; $display("FAIL bstore_rdata_hold got=%h want=0000dead", ReadDataM); end
    idle_cycles(3);
  endtask

  task automatic test_store_block();
    int b;
    int st1;
    int st2;
    b = wr_log.size();
    ack_delay = 3;
    do_store(32'h300, 32'hCAFE_F00D, 4'hF, st1);
    do_store(32'h306, 32'h1234_8765, 4'b1100, st2);
    checks += 2;
    if (st1 !== 0) begin errors++; $display("FAIL block_first_stalls got=%0d want=0", st1); end
    if (st2 !== 2) begin errors++; $display("FAIL block_second_stalls got=%0d want=2", st2); end
    idle_cycles(6);
    checks++;
    if (wr_log.size() - b !== 2) begin errors++; $display("FAIL block_write_count got=%0d want=2", wr_log.size() - b); end
  endtask

  task automatic test_store_then_load();
    logic [31:0] d;
    logic [31:0] ra;
    logic [31:0] want;
    int          st;
    int          wl;
    int          b;
    b = wr_log.size();
    ack_delay = 2;
    do_store(32'h40, 32'h0BAD_C0DE, 4'hF, st);
    want = ref_load(32'h40, 4'hF);
    do_load(32'h40, 4'hF, d, st, ra, wl);
    checks += 3;
    if (wl !== b + 1) begin errors++; $display("FAIL st_ld_order writes_before_read got=%0d want=%0d", wl - b, 1); end
    if (ra !== 32'h40) begin errors++; $display("FAIL st_ld_addr got=%h want=40", ra); end
    if (d !== want)    begin errors++; $display("FAIL st_ld_data got=%h want=%h", d, want); end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    logic [3:0] sbe [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    int total;
    int st;
    int b;
    b = wr_log.size();
    total = 0;
    ack_delay = 1;
    for (int i = 0; i < 8; i++) begin
      do_store(32'($urandom_range(0, 1023)), $urandom, sbe[$urandom_range(0, 6)], st);
      total += st;
    end
    idle_cycles(3);
    checks += 2;
    if (total !== 0) begin errors++; $display("FAIL b2b_stalls got=%0d want=0", total); end
    if (wr_log.size() - b !== 8) begin errors++; $display("FAIL b2b_write_count got=%0d want=8", wr_log.size() - b); end
  endtask

  task automatic test_random();
    logic [3:0]  sbe [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    logic [3:0]  lbe [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111,
                              4'b0110, 4'b0111, 4'b0000, 4'b1001};
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] want;
    logic [31:0] ra;
    logic [3:0]  be;
    int          st;
    int          wl;
    for (int i = 0; i < 60; i++) begin
      ack_delay = $urandom_range(1, 3);
      a = 32'($urandom_range(0, 1023));
      case ($urandom_range(0, 2))
        0: begin
          be = lbe[$urandom_range(0, 10)];
          want = ref_load(a, be);
          do_load(a, be, d, st, ra, wl);
          checks++;
          if (d !== want) begin errors++; $display("FAIL rand_load addr=%h be=%b got=%h want=%h", a, be, d, want); end
        end
        1: do_store(a, $urandom, sbe[$urandom_range(0, 6)], st);
        default: idle_cycles(1);
      endcase
    end
    idle_cycles(8);
  endtask

  task automatic test_write_log();
    checks++;
    if (wr_log.size() !== exp_wr.size()) begin
      errors++;
      $display("FAIL write_log_size got=%0d want=%0d", wr_log.size(), exp_wr.size());
    end
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL write_log[%0d] got addr=%h data=%h be=%b want addr=%h data=%h be=%b", i,
                 wr_log[i].addr, wr_log[i].data, wr_log[i].be,
                 exp_wr[i].addr, exp_wr[i].data, exp_wr[i].be);
      end
    end
  endtask

  initial begin
    reset = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    ByteEnM = 4'h0; AddrM = '0; WriteDataM = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
    test_reset();
    test_reset_mid_read();
    test_word_load();
    test_subword_loads();
    test_posted_store();
    test_store_block();
    test_store_then_load();
    test_back_to_back();
    test_random();
    test_write_log();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
